mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the processor's tagged split-transaction bus, i.e. the far end of the instruction/data cache miss interfaces. Accepts one `BUS_LOAD` or `BUS_STORE` per cycle and answers an accepted load combinationally with a nonzero 4-bit tag. Returns the 64-bit line `LATENCY` cycles later, paired with that tag for exactly one cycle. Sits between the cache/arbiter request port and the backing store; serves as the synthesizable memory model for pipeline simulation.

## Interface
- `LATENCY`, default 4: cycles from load acceptance to data return; legal range 1..14.
- `MEM_WORDS`, default 8192: number of 64-bit words in the backing store; power of two.
- `MAX_OUT`, default 4: outstanding-load limit; used only with `MEM_RESP_THROTTLE_EN`; legal range 1..14.

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `proc2mem_command` in 2: `BUS_NONE`=0, `BUS_LOAD`=1, `BUS_STORE`=2; 3 is treated as `BUS_NONE`.
- `proc2mem_addr` in `XLEN`: byte address; bits [2:0] ignored.
- `proc2mem_data` in 64: store data.
- `mem2proc_response` out 4: tag of the load accepted this cycle; 0 means no load accepted.
- `mem2proc_data` out 64: returned line; 0 whenever `mem2proc_tag`==0.
- `mem2proc_tag` out 4: tag of the line returned this cycle; 0 means none.

## Operation
- Word index is `proc2mem_addr[3 +: log2(MEM_WORDS)]`. An address is in range iff `proc2mem_addr < MEM_WORDS*8`.
- **Tag counter:** `next_tag` cycles 1,2,…,15,1,… and never produces 0. It advances only on load acceptance. Uniqueness of in-flight tags is guaranteed by `LATENCY` ≤ 14.
- **Load:** `mem2proc_response`=`next_tag` in the same cycle (combinational from command). At the edge:
  - the array word is read (0 if out of range);
  - `{valid, tag, data}` enters stage 0 of a `LATENCY`-deep shift pipeline.
- **Store:** never refused; `mem2proc_response`=0. The array word is written at the edge. Out-of-range stores are dropped silently.
- **Return:** `mem2proc_tag` and `mem2proc_data` are registered from the last pipeline stage. Invalid stages output tag 0 and data 0. The pipeline shifts every cycle; there is no stall.
- **Ordering:** a store in cycle N followed by a load of the same word in cycle N+1 returns the new data. A load in cycle N followed by a store in cycle N+1 returns the old data.
- **Outstanding counter** (0..14):
  - +1 on acceptance, −1 on return;
  - both in the same cycle leaves it unchanged.
- **Reset:**
  - pipeline valids cleared, `next_tag`=1, counter=0;
  - `mem2proc_response`=0, `mem2proc_tag`=0, `mem2proc_data`=0;
  - array contents are retained (preloaded by the bench);
  - commands presented during reset are ignored;
  - loads in flight when reset asserts are discarded and their tags are never returned.

## Timing
- Load accepted in cycle N returns in cycle N+`LATENCY` with `mem2proc_tag` equal to the tag given in cycle N. The tag is valid for one cycle.
- Back-to-back loads return back-to-back in issue order.
- A return and a new acceptance in the same cycle are independent.
- The first cycle after reset deasserts can accept a load and gets tag 1.

## Configuration
- `MEM_RESP_THROTTLE_EN` defined: a load presented while the outstanding counter equals `MAX_OUT` is refused.
  - `mem2proc_response`=0.
  - No array read, no tag advance, no counter change.
  - If a return occurs in that same cycle, the load is still refused: the decision uses the registered count.
  - Stores are unaffected.
- Not defined: loads are always accepted and the counter is not used for gating.

## Test plan
- Preload word 0x10=0xA5A5_0000_1234_5678, `LATENCY`=4, reset then `BUS_LOAD` addr 0x80 in cycle 1 -> response=1 in cycle 1; tag=1 with that data in cycle 5; tag=0 and data=0 in cycles 2-4 and 6.
- 16 consecutive loads -> responses 1..15 then 1; returns in the same order, each 4 cycles after issue, with no gaps.
- Store 0xFFFF_0000_FFFF_0000 to 0x40 in cycle N, load 0x40 in N+1 -> response 0 for the store; the load returns 0xFFFF_0000_FFFF_0000. Reverse order -> the load returns the old value.
- Load at address `MEM_WORDS*8` -> accepted, returns data 0. Store there -> word 0 unchanged.
- Reset asserted 2 cycles after a load -> tag never returned; after release the first load gets tag 1.
- With `MEM_RESP_THROTTLE_EN`, `MAX_OUT`=2, three consecutive loads -> responses 1, 2, 0. Retrying the third load in cycle N+4, when tag 1 returns -> still 0; retry in N+5 -> response 3.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the tagged split-transaction bus: fixed-latency load returns with tags.
// Optional MEM_RESP_THROTTLE_EN refuses loads while MAX_OUT loads are outstanding.
module mem_responder #(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 8192,
  parameter int MAX_OUT   = 4,
  parameter int XLEN      = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      proc2mem_command,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      mem2proc_tag
);

  localparam int          AW         = $clog2(MEM_WORDS);
  localparam logic [1:0]  BUS_LOAD   = 2'd1;
  localparam logic [1:0]  BUS_STORE  = 2'd2;
  localparam logic [63:0] ADDR_LIMIT = 64'(MEM_WORDS) * 64'd8;
`ifdef MEM_RESP_THROTTLE_EN
  localparam bit THROTTLE = 1'b1;
`else
  localparam bit THROTTLE = 1'b0;
`endif

  logic [63:0]   mem [MEM_WORDS];

  logic          vld_p  [LATENCY];
  logic [3:0]    tag_p  [LATENCY];
  logic [63:0]   data_p [LATENCY];

  logic [3:0]    next_tag;
  logic [3:0]    outstanding;
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          is_load;
  logic          is_store;
  logic          at_limit;
  logic          accept;
  logic          ret;

  assign word_idx = proc2mem_addr[3 +: AW];
  assign in_range = 64'(proc2mem_addr) < ADDR_LIMIT;
  assign is_load  = !reset && (proc2mem_command == BUS_LOAD);
  assign is_store = !reset && (proc2mem_command == BUS_STORE);
  // Gating uses the registered count, so a same-cycle return does not free a slot.
  assign at_limit = (outstanding == 4'(MAX_OUT));
  assign accept   = is_load && !(THROTTLE && at_limit);
  assign ret      = vld_p[LATENCY-1];

  assign mem2proc_response = accept ? next_tag : 4'd0;
  assign mem2proc_tag      = ret ? tag_p[LATENCY-1]  : 4'd0;
  assign mem2proc_data     = ret ? data_p[LATENCY-1] : 64'd0;

  // Control: valids, tag counter, outstanding count
  always_ff @(posedge clock) begin
    if (reset) begin
      next_tag    <= 4'd1;
      outstanding <= 4'd0;
      for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
      if (accept) next_tag <= (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
      case ({accept, ret})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Data: tag/line pipeline, qualified by vld_p and never reset
  always_ff @(posedge clock) begin
    if (accept) begin
      tag_p[0]  <= next_tag;
      data_p[0] <= in_range ? mem[word_idx] : 64'd0;
    end
    for (int i = 1; i < LATENCY; i++) begin
      tag_p[i]  <= tag_p[i-1];
      data_p[i] <= data_p[i-1];
    end
  end

  // Backing store: read above sees the pre-edge contents, so load-then-store returns old data.
  always_ff @(posedge clock) begin
    if (is_store && in_range) mem[word_idx] <= proc2mem_data;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=4, MEM_WORDS=8192).
module tb_mem_responder;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;
`ifdef MEM_RESP_THROTTLE_EN
  localparam int MAX_OUT_TB = 2;
`else
  localparam int MAX_OUT_TB = 4;
`endif
  localparam logic [63:0] LINE_A = 64'hA5A5_0000_1234_5678;

  logic        clock;
  logic        reset;
  logic [1:0]  cmd;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [3:0]  resp;
  logic [63:0] rdata;
  logic [3:0]  rtag;

  int checks = 0;
  int errors = 0;

  mem_responder #(
    .LATENCY(4), .MEM_WORDS(8192), .MAX_OUT(MAX_OUT_TB), .XLEN(32)
  ) dut (
    .clock(clock), .reset(reset),
    .proc2mem_command(cmd), .proc2mem_addr(addr), .proc2mem_data(wdata),
    .mem2proc_response(resp), .mem2proc_data(rdata), .mem2proc_tag(rtag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One cycle: drive at the falling edge, outputs settle 1 time unit later.
  task automatic drive(input logic r, input logic [1:0] c, input logic [31:0] a,
                       input logic [63:0] d);
    @(negedge clock);
    reset = r; cmd = c; addr = a; wdata = d;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, NONE, 32'd0, 64'd0);
  endtask

  task automatic test_reset();
    drive(1'b1, LOAD, 32'h80, 64'd0);
    drive(1'b1, LOAD, 32'h80, 64'd0);
    checks++; if (resp !== 4'd0)  begin errors++; $display("FAIL reset_resp got=%0h exp=0", resp); end
    checks++; if (rtag !== 4'd0)  begin errors++; $display("FAIL reset_tag got=%0h exp=0", rtag); end
    checks++; if (rdata !== 64'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", rdata); end
  endtask

  task automatic test_single_load();
    drive(1'b0, STORE, 32'h80, LINE_A);
    checks++; if (resp !== 4'd0) begin errors++; $display("FAIL store_resp got=%0h exp=0", resp); end
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      if (c == 1) drive(1'b0, LOAD, 32'h80, 64'd0);
      else        drive(1'b0, NONE, 32'd0, 64'd0);
      if (c == 1) begin
        checks++; if (resp !== 4'd1) begin errors++; $display("FAIL single_resp got=%0h exp=1", resp); end
      end
      if (c == 5) begin
        checks++; if (rtag !== 4'd1) begin errors++; $display("FAIL single_tag c=%0d got=%0h exp=1", c, rtag); end
        checks++; if (rdata !== LINE_A) begin errors++; $display("FAIL single_data c=%0d got=%h exp=%h", c, rdata, LINE_A); end
      end else begin
        checks++; if (rtag !== 4'd0) begin errors++; $display("FAIL single_idle_tag c=%0d got=%0h exp=0", c, rtag); end
        checks++; if (rdata !== 64'd0) begin errors++; $display("FAIL single_idle_data c=%0d got=%h exp=0", c, rdata); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  et;
    logic [63:0] ed;
    for (int j = 1; j <= 16; j++)
      drive(1'b0, STORE, 32'h200 + 32'((j - 1) * 8), 64'hB0B0_0000_0000_0000 + 64'(j));
    do_reset();
    for (int c = 1; c <= 21; c++) begin
      if (c <= 16) drive(1'b0, LOAD, 32'h200 + 32'((c - 1) * 8), 64'd0);
      else         drive(1'b0, NONE, 32'd0, 64'd0);
      et = (c <= 16) ? 4'(((c - 1) % 15) + 1) : 4'd0;
      checks++; if (resp !== et) begin errors++; $display("FAIL b2b_resp c=%0d got=%0h exp=%0h", c, resp, et); end
      if (c >= 5 && c <= 20) begin
        et = 4'(((c - 5) % 15) + 1);
        ed = 64'hB0B0_0000_0000_0000 + 64'(c - 4);
      end else begin
        et = 4'd0;
        ed = 64'd0;
      end
      checks++; if (rtag !== et) begin errors++; $display("FAIL b2b_tag c=%0d got=%0h exp=%0h", c, rtag, et); end
      checks++; if (rdata !== ed) begin errors++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, rdata, ed); end
    end
  endtask

  task automatic test_store_load_order();
    do_reset();
    drive(1'b0, STORE, 32'h40, 64'hFFFF_0000_FFFF_0000);
    checks++; if (resp !== 4'd0) begin errors++; $display("FAIL order_store_resp got=%0h exp=0", resp); end
    drive(1'b0, LOAD, 32'h40, 64'd0);
    checks++; if (resp !== 4'd1) begin errors++; $display("FAIL order_load1_resp got=%0h exp=1", resp); end
    drive(1'b0, STORE, 32'h48, 64'h1111_1111_1111_1111);
    drive(1'b0, LOAD, 32'h48, 64'd0);
    checks++; if (resp !== 4'd2) begin errors++; $display("FAIL order_load2_resp got=%0h exp=2", resp); end
    drive(1'b0, STORE, 32'h48, 64'h2222_2222_2222_2222);
    drive(1'b0, NONE, 32'd0, 64'd0);
    checks++; if (rtag !== 4'd1) begin errors++; $display("FAIL order_tag1 got=%0h exp=1", rtag); end
    checks++; if (rdata !== 64'hFFFF_0000_FFFF_0000) begin errors++; $display("FAIL order_new_data got=%h exp=ffff0000ffff0000", rdata); end
    drive(1'b0, NONE, 32'd0, 64'd0);
    checks++; if (rtag !== 4'd0) begin errors++; $display("FAIL order_gap_tag got=%0h exp=0", rtag); end
    drive(1'b0, NONE, 32'd0, 64'd0);
    checks++; if (rtag !== 4'd2) begin errors++; $display("FAIL order_tag2 got=%0h exp=2", rtag); end
    checks++; if (rdata !== 64'h1111_1111_1111_1111) begin errors++; $display("FAIL order_old_data got=%h exp=1111111111111111", rdata); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    drive(1'b0, STORE, 32'h0, 64'h0123_4567_89AB_CDEF);
    drive(1'b0, STORE, 32'h10000, 64'hDEAD_DEAD_DEAD_DEAD);
    drive(1'b0, LOAD, 32'h10000, 64'd0);
    checks++; if (resp !== 4'd1) begin errors++; $display("FAIL oor_resp got=%0h exp=1", resp); end
    drive(1'b0, LOAD, 32'h0, 64'd0);
    drive(1'b0, NONE, 32'd0, 64'd0);
    drive(1'b0, NONE, 32'd0, 64'd0);
    drive(1'b0, NONE, 32'd0, 64'd0);
    checks++; if (rtag !== 4'd1) begin errors++; $display("FAIL oor_tag got=%0h exp=1", rtag); end
    checks++; if (rdata !== 64'd0) begin errors++; $display("FAIL oor_data got=%h exp=0", rdata); end
    drive(1'b0, NONE, 32'd0, 64'd0);
    checks++; if (rtag !== 4'd2) begin errors++; $display("FAIL oor_word0_tag got=%0h exp=2", rtag); end
    checks++; if (rdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL oor_word0_data got=%h exp=0123456789abcdef", rdata); end
  endtask

  task automatic test_reset_discard();
    do_reset();
    drive(1'b0, LOAD, 32'h80, 64'd0);
    checks++; if (resp !== 4'd1) begin errors++; $display("FAIL discard_first_resp got=%0h exp=1", resp); end
    drive(1'b0, NONE, 32'd0, 64'd0);
    drive(1'b1, LOAD, 32'h80, 64'd0);
    checks++; if (resp !== 4'd0) begin errors++; $display("FAIL discard_inreset_resp got=%0h exp=0", resp); end
    drive(1'b0, LOAD, 32'h80, 64'd0);
    checks++; if (resp !== 4'd1) begin errors++; $display("FAIL discard_after_resp got=%0h exp=1", resp); end
    for (int c = 5; c <= 8; c++) begin
      drive(1'b0, NONE, 32'd0, 64'd0);
      if (c < 8) begin
        checks++; if (rtag !== 4'd0) begin errors++; $display("FAIL discard_tag c=%0d got=%0h exp=0", c, rtag); end
      end else begin
        checks++; if (rtag !== 4'd1) begin errors++; $display("FAIL discard_new_tag got=%0h exp=1", rtag); end
        checks++; if (rdata !== LINE_A) begin errors++; $display("FAIL discard_new_data got=%h exp=%h", rdata, LINE_A); end
      end
    end
  endtask

`ifdef MEM_RESP_THROTTLE_EN
  task automatic test_throttle();
    do_reset();
    drive(1'b0, LOAD, 32'h80, 64'd0);
    checks++; if (resp !== 4'd1) begin errors++; $display("FAIL thr_resp1 got=%0h exp=1", resp); end
    drive(1'b0, LOAD, 32'h80, 64'd0);
    checks++; if (resp !== 4'd2) begin errors++; $display("FAIL thr_resp2 got=%0h exp=2", resp); end
    drive(1'b0, LOAD, 32'h80, 64'd0);
    checks++; if (resp !== 4'd0) begin errors++; $display("FAIL thr_refuse got=%0h exp=0", resp); end
    drive(1'b0, STORE, 32'h300, 64'h5);
    checks++; if (resp !== 4'd0) begin errors++; $display("FAIL thr_store_resp got=%0h exp=0", resp); end
    drive(1'b0, LOAD, 32'h80, 64'd0);
    checks++; if (rtag !== 4'd1) begin errors++; $display("FAIL thr_ret_tag got=%0h exp=1", rtag); end
    checks++; if (resp !== 4'd0) begin errors++; $display("FAIL thr_same_cycle got=%0h exp=0", resp); end
    drive(1'b0, LOAD, 32'h80, 64'd0);
    checks++; if (resp !== 4'd3) begin errors++; $display("FAIL thr_retry got=%0h exp=3", resp); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd = NONE; addr = 32'd0; wdata = 64'd0;
    test_reset();
    test_single_load();
    test_back_to_back();
    test_store_load_order();
    test_out_of_range();
    test_reset_discard();
`ifdef MEM_RESP_THROTTLE_EN
    test_throttle();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
